// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-lite master controller.
//   ADDRWIDTH / DATAWIDTH : default bus widths (DATAWIDTH must be 32 or 64)
//   resp_t                : AXI response encodings
//   wr_state_t            : write FSM states
//   rd_state_t            : read FSM states
package axi4lite_pkg;

    localparam int ADDRWIDTH = 32;
    localparam int DATAWIDTH = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SEND,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi4lite_rd_ctrl.sv
// Read side of the AXI4-lite master: read FSM plus the AR and R channels.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rd_en, rd_addr        : read request, sampled only while rd_busy is low
//   rd_busy, rd_done      : FSM not idle / one-cycle completion pulse
//   rd_data, rd_resp      : RDATA/RRESP captured at the R handshake
//   araddr/arvalid/arprot : read address channel outputs, arready input
//   rdata/rresp/rvalid    : read data channel inputs, rready output
// Every output comes straight from a register.
module axi4lite_rd_ctrl
    import axi4lite_pkg::*;
#(
    parameter int ADDRWIDTH = axi4lite_pkg::ADDRWIDTH,
    parameter int DATAWIDTH = axi4lite_pkg::DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic [ADDRWIDTH-1:0] rd_addr,
    output logic                 rd_busy,
    output logic                 rd_done,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic [1:0]           rd_resp,
    output logic [ADDRWIDTH-1:0] araddr,
    output logic                 arvalid,
    output logic [2:0]           arprot,
    input  logic                 arready,
    input  logic [DATAWIDTH-1:0] rdata,
    input  logic [1:0]           rresp,
    input  logic                 rvalid,
    output logic                 rready
);

    rd_state_t            state_reg, state_next;
    logic [ADDRWIDTH-1:0] araddr_reg, araddr_next;
    logic                 arvalid_reg, arvalid_next;
    logic                 rready_reg, rready_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic [DATAWIDTH-1:0] rd_data_reg, rd_data_next;
    resp_t                rd_resp_reg, rd_resp_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= R_IDLE;
            araddr_reg  <= '0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            rd_data_reg <= '0;
            rd_resp_reg <= OKAY;
        end else begin
            state_reg   <= state_next;
            araddr_reg  <= araddr_next;
            arvalid_reg <= arvalid_next;
            rready_reg  <= rready_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            rd_data_reg <= rd_data_next;
            rd_resp_reg <= rd_resp_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        araddr_next  = araddr_reg;
        arvalid_next = arvalid_reg;
        rready_next  = rready_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        rd_data_next = rd_data_reg;
        rd_resp_next = rd_resp_reg;
        case (state_reg)
            R_IDLE: begin
                if (rd_en) begin
                    araddr_next  = rd_addr;
                    arvalid_next = 1'b1;
                    busy_next    = 1'b1;
                    state_next   = R_ADDR;
                end
            end
            R_ADDR: begin
                // RREADY is only raised once the address has been taken, so
                // the data phase can never precede its own address phase.
                if (arvalid_reg && arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid && rready_reg) begin
                    rd_data_next = rdata;
                    rd_resp_next = resp_t'(rresp);
                    rready_next  = 1'b0;
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    state_next   = R_IDLE;
                end
            end
            default: state_next = R_IDLE;
        endcase
    end

    assign araddr  = araddr_reg;
    assign arvalid = arvalid_reg;
    assign arprot  = 3'b000;
    assign rready  = rready_reg;
    assign rd_busy = busy_reg;
    assign rd_done = done_reg;
    assign rd_data = rd_data_reg;
    assign rd_resp = rd_resp_reg;

endmodule

// File: rtl/axi4lite_master_ctrl.sv
// AXI4-lite master controller: turns wr_en/rd_en request strobes into
// AW/W/B and AR/R channel handshakes. Read and write sides are independent.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   wr_en, Write_Address, Write_Data  : write request (ignored while wr_busy)
//   wr_busy, wr_done, wr_resp         : write status, done pulse, BRESP
//   rd_en, Read_Address               : read request (ignored while rd_busy)
//   rd_busy, rd_done, rd_data, rd_resp: read status, done pulse, RDATA/RRESP
//   AW*/W*/B*/AR*/R*                  : AXI4-lite master channel signals
// DATAWIDTH must be 32 or 64. WSTRB is tied to all ones: only full-word
// writes are issued.
module axi4lite_master_ctrl
    import axi4lite_pkg::*;
#(
    parameter int ADDRWIDTH = axi4lite_pkg::ADDRWIDTH,
    parameter int DATAWIDTH = axi4lite_pkg::DATAWIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ADDRWIDTH-1:0]   Write_Address,
    input  logic [DATAWIDTH-1:0]   Write_Data,
    input  logic                   rd_en,
    input  logic [ADDRWIDTH-1:0]   Read_Address,
    output logic                   wr_busy,
    output logic                   wr_done,
    output logic [1:0]             wr_resp,
    output logic                   rd_busy,
    output logic                   rd_done,
    output logic [DATAWIDTH-1:0]   rd_data,
    output logic [1:0]             rd_resp,
    output logic [ADDRWIDTH-1:0]   AWADDR,
    output logic                   AWVALID,
    output logic [2:0]             AWPROT,
    input  logic                   AWREADY,
    output logic [DATAWIDTH-1:0]   WDATA,
    output logic [DATAWIDTH/8-1:0] WSTRB,
    output logic                   WVALID,
    input  logic                   WREADY,
    input  logic [1:0]             BRESP,
    input  logic                   BVALID,
    output logic                   BREADY,
    output logic [ADDRWIDTH-1:0]   ARADDR,
    output logic                   ARVALID,
    output logic [2:0]             ARPROT,
    input  logic                   ARREADY,
    input  logic [DATAWIDTH-1:0]   RDATA,
    input  logic [1:0]             RRESP,
    input  logic                   RVALID,
    output logic                   RREADY
);

    localparam int STRB_W = DATAWIDTH / 8;

    wr_state_t            wr_state_reg, wr_state_next;
    logic [ADDRWIDTH-1:0] awaddr_reg, awaddr_next;
    logic [DATAWIDTH-1:0] wdata_reg, wdata_next;
    logic                 awvalid_reg, awvalid_next;
    logic                 wvalid_reg, wvalid_next;
    logic                 bready_reg, bready_next;
    logic                 aw_done_reg, aw_done_next;
    logic                 w_done_reg, w_done_next;
    logic                 wr_busy_reg, wr_busy_next;
    logic                 wr_done_reg, wr_done_next;
    resp_t                wr_resp_reg, wr_resp_next;
    logic                 aw_hs, w_hs;

    assign aw_hs = awvalid_reg && AWREADY;
    assign w_hs  = wvalid_reg && WREADY;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_reg <= W_IDLE;
            awaddr_reg   <= '0;
            wdata_reg    <= '0;
            awvalid_reg  <= 1'b0;
            wvalid_reg   <= 1'b0;
            bready_reg   <= 1'b0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            wr_busy_reg  <= 1'b0;
            wr_done_reg  <= 1'b0;
            wr_resp_reg  <= OKAY;
        end else begin
            wr_state_reg <= wr_state_next;
            awaddr_reg   <= awaddr_next;
            wdata_reg    <= wdata_next;
            awvalid_reg  <= awvalid_next;
            wvalid_reg   <= wvalid_next;
            bready_reg   <= bready_next;
            aw_done_reg  <= aw_done_next;
            w_done_reg   <= w_done_next;
            wr_busy_reg  <= wr_busy_next;
            wr_done_reg  <= wr_done_next;
            wr_resp_reg  <= wr_resp_next;
        end
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        awaddr_next   = awaddr_reg;
        wdata_next    = wdata_reg;
        awvalid_next  = awvalid_reg;
        wvalid_next   = wvalid_reg;
        bready_next   = bready_reg;
        aw_done_next  = aw_done_reg;
        w_done_next   = w_done_reg;
        wr_busy_next  = wr_busy_reg;
        wr_done_next  = 1'b0;
        wr_resp_next  = wr_resp_reg;
        case (wr_state_reg)
            W_IDLE: begin
                if (wr_en) begin
                    awaddr_next   = Write_Address;
                    wdata_next    = Write_Data;
                    awvalid_next  = 1'b1;
                    wvalid_next   = 1'b1;
                    aw_done_next  = 1'b0;
                    w_done_next   = 1'b0;
                    wr_busy_next  = 1'b1;
                    wr_state_next = W_SEND;
                end
            end
            W_SEND: begin
                // AW and W finish independently; the flags remember which one
                // has already handshaked so either order (or both at once) works.
                if (aw_hs) begin
                    awvalid_next = 1'b0;
                    aw_done_next = 1'b1;
                end
                if (w_hs) begin
                    wvalid_next = 1'b0;
                    w_done_next = 1'b1;
                end
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                    bready_next   = 1'b1;
                    wr_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (BVALID && bready_reg) begin
                    wr_resp_next  = resp_t'(BRESP);
                    bready_next   = 1'b0;
                    wr_done_next  = 1'b1;
                    wr_busy_next  = 1'b0;
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    assign AWADDR  = awaddr_reg;
    assign AWVALID = awvalid_reg;
    assign AWPROT  = 3'b000;
    assign WDATA   = wdata_reg;
    assign WVALID  = wvalid_reg;
    assign BREADY  = bready_reg;
    assign wr_busy = wr_busy_reg;
    assign wr_done = wr_done_reg;
    assign wr_resp = wr_resp_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_wstrb
            assign WSTRB[gi] = 1'b1;
        end
    endgenerate

    axi4lite_rd_ctrl #(
        .ADDRWIDTH (ADDRWIDTH),
        .DATAWIDTH (DATAWIDTH)
    ) u_rd_ctrl (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en),
        .rd_addr (Read_Address),
        .rd_busy (rd_busy),
        .rd_done (rd_done),
        .rd_data (rd_data),
        .rd_resp (rd_resp),
        .araddr  (ARADDR),
        .arvalid (ARVALID),
        .arprot  (ARPROT),
        .arready (ARREADY),
        .rdata   (RDATA),
        .rresp   (RRESP),
        .rvalid  (RVALID),
        .rready  (RREADY)
    );

endmodule
